// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the runtime-configurable UART receiver.
package uart_rx_cfg_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int PRESCALE_W    = 6;
    localparam int MIN_DATA_LEN  = 5;
    localparam int MAX_STOP_BITS = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_cfg_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_majority_sampler.sv
// Per-bit edge counter with 3-sample majority capture around the bit centre.
module rx_majority_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  start,
    input  logic                  run,
    output logic                  sample_bit,
    output logic                  sample_stb,
    output logic                  bit_done
);
    import uart_rx_cfg_pkg::*;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  s0_p0;
    logic                  s1_p0;

    assign half       = prescale >> 1;
    assign sample_stb = run && (edge_cnt == half + PRESCALE_W'(1));
    assign bit_done   = run && (edge_cnt == prescale - PRESCALE_W'(1));
    assign sample_bit = majority3(s0_p0, s1_p0, rx_in);

    // The detecting IDLE cycle is edge 0, so the counter resumes at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (start) begin
            edge_cnt <= PRESCALE_W'(1);
        end else if (run) begin
            edge_cnt <= (edge_cnt == prescale - PRESCALE_W'(1)) ? '0 : edge_cnt + PRESCALE_W'(1);
        end else begin
            edge_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (edge_cnt == half - PRESCALE_W'(1)) s0_p0 <= rx_in;
        if (edge_cnt == half)                  s1_p0 <= rx_in;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-8 data bits, optional parity, 1 or 2 stop bits.
module uart_rx_cfg #(
    parameter int MAX_DATA_W = uart_rx_cfg_pkg::DATA_WIDTH,
    parameter int PRESCALE_W = uart_rx_cfg_pkg::PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic [1:0]            data_len,
    input  logic                  two_stop,
    output logic                  rx_busy,
    output logic                  Data_Valid,
    output logic [MAX_DATA_W-1:0] P_DATA,
    output logic                  par_err,
    output logic                  framing_error
);
    import uart_rx_cfg_pkg::*;

    localparam int CNT_W = $clog2(MAX_DATA_W + 1);

    rx_cfg_state_t         state;
    rx_cfg_state_t         next_state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic [1:0]            data_len_q;
    logic                  two_stop_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      frame_len;
    logic [MAX_DATA_W-1:0] shreg_p0;
    logic                  par_flag;
    logic                  frm_flag;
    logic                  start_det;
    logic                  run;
    logic                  sample_bit;
    logic                  sample_stb;
    logic                  bit_done;
    logic                  frame_done;

    assign start_det = (state == IDLE) && !RX_IN;
    assign run       = (state != IDLE);
    assign frame_len = CNT_W'(MIN_DATA_LEN) + CNT_W'(data_len_q);

    rx_majority_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .rx_in      (RX_IN),
        .prescale   (prescale_q),
        .start      (start_det),
        .run        (run),
        .sample_bit (sample_bit),
        .sample_stb (sample_stb),
        .bit_done   (bit_done)
    );

    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START: begin
                if (sample_stb && sample_bit) next_state = IDLE;
                else if (bit_done)            next_state = DATA;
            end
            DATA: begin
                if (bit_done && (bit_cnt == frame_len - CNT_W'(1)))
                    next_state = par_en_q ? PARITY : STOP1;
            end
            PARITY: if (bit_done) next_state = STOP1;
            STOP1: begin
                if (bit_done) begin
                    if (two_stop_q) begin
                        next_state = STOP2;
                    end else begin
                        next_state = IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_done) begin
                    next_state = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            prescale_q    <= PRESCALE_W'(8);
            par_en_q      <= 1'b0;
            par_type_q    <= 1'b0;
            data_len_q    <= 2'b00;
            two_stop_q    <= 1'b0;
            bit_cnt       <= '0;
            par_flag      <= 1'b0;
            frm_flag      <= 1'b0;
            rx_busy       <= 1'b0;
            Data_Valid    <= 1'b0;
            par_err       <= 1'b0;
            framing_error <= 1'b0;
            P_DATA        <= '0;
        end else begin
            state         <= next_state;
            rx_busy       <= (next_state != IDLE);
            Data_Valid    <= 1'b0;
            par_err       <= 1'b0;
            framing_error <= 1'b0;

            if (start_det) begin
                prescale_q <= Prescale;
                par_en_q   <= parity_enable;
                par_type_q <= parity_type;
                data_len_q <= data_len;
                two_stop_q <= two_stop;
                bit_cnt    <= '0;
                par_flag   <= 1'b0;
                frm_flag   <= 1'b0;
            end

            if (state == DATA && bit_done)
                bit_cnt <= (bit_cnt == frame_len - CNT_W'(1)) ? '0 : bit_cnt + CNT_W'(1);

            // Unused low shift positions stay zero, so they drop out of the XOR.
            if (state == PARITY && sample_stb && (sample_bit != (^shreg_p0 ^ par_type_q)))
                par_flag <= 1'b1;

            if ((state == STOP1 || state == STOP2) && sample_stb && !sample_bit)
                frm_flag <= 1'b1;

            if (frame_done) begin
                if (!par_flag && !frm_flag) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shreg_p0 >> (CNT_W'(MAX_DATA_W) - frame_len);
                end
                par_err       <= par_flag;
                framing_error <= frm_flag;
            end
        end
    end

    // Data enters at the MSB; the frame is right-aligned on completion.
    always_ff @(posedge CLK) begin
        if (start_det)
            shreg_p0 <= '0;
        else if (state == DATA && sample_stb)
            shreg_p0 <= {sample_bit, shreg_p0[MAX_DATA_W-1:1]};
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame table plus glitch and mid-frame reset sequences.
module tb_uart_rx_cfg;
    import uart_rx_cfg_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       parity_enable;
    logic       parity_type;
    logic [1:0] data_len;
    logic       two_stop;
    logic       rx_busy;
    logic       Data_Valid;
    logic [7:0] P_DATA;
    logic       par_err;
    logic       framing_error;

    always #5 CLK = ~CLK;

    uart_rx_cfg #(
        .MAX_DATA_W (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .Prescale      (Prescale),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .data_len      (data_len),
        .two_stop      (two_stop),
        .rx_busy       (rx_busy),
        .Data_Valid    (Data_Valid),
        .P_DATA        (P_DATA),
        .par_err       (par_err),
        .framing_error (framing_error)
    );

    typedef struct {
        int         p;
        logic       pe;
        logic       pt;
        logic [1:0] dl;
        logic       ts;
        logic [7:0] data;
        logic       flip;
        logic       s1low;
        logic       s2low;
        logic       gap;
        logic       dv;
        logic       perr;
        logic       ferr;
        logic [7:0] pd;
    } vec_t;

    vec_t vecs [0:9];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame starting right after a posedge; returns after all bit
    // periods, or after 'limit' clock edges when limit is nonzero.
    task automatic send_frame(input vec_t v, input int limit, output int early);
        logic       line [0:15];
        logic [7:0] m;
        int         nb;
        int         len;
        int         k;
        len = MIN_DATA_LEN + int'(v.dl);
        m   = 8'((1 << len) - 1);
        nb  = 0;
        line[nb] = 1'b0; nb++;
        for (int i = 0; i < len; i++) begin
            line[nb] = v.data[i]; nb++;
        end
        if (v.pe) begin
            line[nb] = (^(v.data & m)) ^ v.pt ^ v.flip; nb++;
        end
        line[nb] = !v.s1low; nb++;
        if (v.ts) begin
            for (int i = 1; i < MAX_STOP_BITS; i++) begin
                line[nb] = !v.s2low; nb++;
            end
        end
        Prescale      = 6'(v.p);
        parity_enable = v.pe;
        parity_type   = v.pt;
        data_len      = v.dl;
        two_stop      = v.ts;
        early = 0;
        k     = 0;
        for (int b = 0; b < nb; b++) begin
            RX_IN = line[b];
            for (int c = 0; c < v.p; c++) begin
                @(posedge CLK); #1;
                k++;
                if (k == 1) begin
                    check("busy_rise", int'(rx_busy), 1);
                    Prescale      = (v.p == 8) ? 6'd16 : 6'd8;
                    parity_enable = ~v.pe;
                    parity_type   = ~v.pt;
                    data_len      = ~v.dl;
                    two_stop      = ~v.ts;
                end
                if (k < nb * v.p && (Data_Valid || par_err || framing_error)) early++;
                if (k == limit) return;
            end
        end
    endtask

    initial begin
        int   early;
        int   busy_cnt;
        int   pulses;
        vec_t v;

        RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8;
        parity_enable = 1'b0; parity_type = 1'b0; data_len = 2'b11; two_stop = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", int'(rx_busy), 0);
        check("rst_dv", int'(Data_Valid), 0);
        check("rst_perr", int'(par_err), 0);
        check("rst_ferr", int'(framing_error), 0);
        check("rst_pdata", int'(P_DATA), 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        //         p   pe    pt    dl     ts    data   flip  s1lo  s2lo  gap   dv    perr  ferr  pd
        vecs[0] = '{8,  1'b0, 1'b0, 2'd3, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{16, 1'b1, 1'b0, 2'd2, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h35};
        vecs[2] = '{16, 1'b1, 1'b0, 2'd2, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35};
        vecs[3] = '{32, 1'b1, 1'b1, 2'd0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1F};
        vecs[4] = '{32, 1'b1, 1'b1, 2'd0, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0A};
        vecs[5] = '{8,  1'b0, 1'b0, 2'd3, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A};
        vecs[6] = '{16, 1'b1, 1'b1, 2'd1, 1'b0, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2B};
        vecs[7] = '{8,  1'b1, 1'b0, 2'd2, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2B};
        vecs[8] = '{8,  1'b0, 1'b0, 2'd1, 1'b0, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2B};
        vecs[9] = '{16, 1'b0, 1'b0, 2'd0, 1'b0, 8'hF5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h15};

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i], 0, early);
            check($sformatf("v%0d_dv", i), int'(Data_Valid), int'(vecs[i].dv));
            check($sformatf("v%0d_perr", i), int'(par_err), int'(vecs[i].perr));
            check($sformatf("v%0d_ferr", i), int'(framing_error), int'(vecs[i].ferr));
            check($sformatf("v%0d_pdata", i), int'(P_DATA), int'(vecs[i].pd));
            check($sformatf("v%0d_busy_fall", i), int'(rx_busy), 0);
            check($sformatf("v%0d_early_pulse", i), early, 0);
            if (vecs[i].gap) begin
                RX_IN = 1'b1;
                @(posedge CLK); #1;
                check($sformatf("v%0d_pulse_width", i),
                      int'({Data_Valid, par_err, framing_error}), 0);
            end
        end

        // Short low glitch on an idle line must be rejected at the start-bit centre.
        RX_IN = 1'b1; Prescale = 6'd16;
        repeat (4) @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        busy_cnt = 0;
        pulses   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (k == 3) RX_IN = 1'b1;
            if (rx_busy) busy_cnt++;
            if (Data_Valid || par_err || framing_error) pulses++;
        end
        check("glitch_busy_cycles", busy_cnt, 9);
        check("glitch_pulses", pulses, 0);
        check("glitch_pdata", int'(P_DATA), 8'h15);

        // Reset in the middle of the data bits aborts the frame.
        v = '{8, 1'b0, 1'b0, 2'd3, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77};
        send_frame(v, 40, early);
        RST = 1'b1;
        #1;
        check("abort_busy", int'(rx_busy), 0);
        check("abort_dv", int'(Data_Valid), 0);
        check("abort_perr", int'(par_err), 0);
        check("abort_ferr", int'(framing_error), 0);
        check("abort_pdata", int'(P_DATA), 0);
        RX_IN = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        v = '{8, 1'b0, 1'b0, 2'd3, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C};
        send_frame(v, 0, early);
        check("post_rst_dv", int'(Data_Valid), 1);
        check("post_rst_pdata", int'(P_DATA), 8'h3C);
        check("post_rst_errs", int'({par_err, framing_error}), 0);
        check("post_rst_early", early, 0);
        RX_IN = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_width", int'(Data_Valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
